// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1-to-2 output demultiplexer.
package demux_pkg;

    localparam int DEMUX_WIDTH = 16;
    localparam int DEMUX_CNT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    localparam int CH0 = 0;
    localparam int CH1 = 1;

endpackage

// File: rtl/demux_slot.sv
// One output channel: one-entry holding register with valid/ready handshake
// and a saturating count of delivered words.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             out_ready,
    output logic             free,
    output logic             out_valid,
    output logic [WIDTH-1:0] d_out,
    output logic [CNT_W-1:0] cnt
);

    ch_state_t        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain;

    always_comb begin
        drain   = (state_q == FULL) && out_ready;
        free    = (state_q == EMPTY) || out_ready;
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL:  if (drain && !load) state_d = EMPTY;
        endcase
        // Data is left in place after a drain; only a new load overwrites it.
        if (load) data_d = d_in;
        if (drain && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign d_out     = data_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/demux_out.sv
// Registered 1-to-2 demultiplexer: steers each accepted word to the channel
// chosen by sel. Define DEMUX_BCAST_EN to add the bcast (load both) input.
module demux_out
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] D_in,
    input  logic             in_valid,
    input  logic             sel,
`ifdef DEMUX_BCAST_EN
    input  logic             bcast,
`endif
    output logic             in_ready,
    output logic [WIDTH-1:0] D_out0,
    output logic [WIDTH-1:0] D_out1,
    output logic             out_valid0,
    output logic             out_valid1,
    input  logic             out_ready0,
    input  logic             out_ready1,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic [1:0] free;
    logic [1:0] load;
    logic       to0, to1;
    logic       accept;

    // in_ready depends only on the targeted channel(s), never on in_valid.
    always_comb begin
        to0      = !sel;
        to1      = sel;
        in_ready = free[sel];
`ifdef DEMUX_BCAST_EN
        if (bcast) begin
            to0      = 1'b1;
            to1      = 1'b1;
            in_ready = free[CH0] && free[CH1];
        end
`endif
        accept    = in_valid && in_ready;
        load[CH0] = accept && to0;
        load[CH1] = accept && to1;
    end

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load[CH0]),
        .d_in      (D_in),
        .out_ready (out_ready0),
        .free      (free[CH0]),
        .out_valid (out_valid0),
        .d_out     (D_out0),
        .cnt       (cnt0)
    );

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load[CH1]),
        .d_in      (D_in),
        .out_ready (out_ready1),
        .free      (free[CH1]),
        .out_valid (out_valid1),
        .d_out     (D_out1),
        .cnt       (cnt1)
    );

endmodule
